// File: rtl/image_memory_streamer.sv
// image_memory_streamer: issues a run of sequential 1-cycle-latency reads and streams
// the pixels out through a 2-entry FIFO. Optional range check: IMG_STREAM_BOUND_CHECK_EN.
module image_memory_streamer #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int IMG_SIZE = 160000,
  parameter int LEN_W    = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              err_q, err_d;
  logic              rd_pend_q;
  logic              rd_last_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;

  logic              issue;
  logic              push;
  logic              pop;
  logic              range_bad;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  assign push = rd_pend_q;
  assign pop  = (count_q != 2'd0) && pix_ready;

  // Slots already spoken for once this cycle's pop leaves: FIFO entries plus the
  // read whose data lands this cycle. A new read may only claim a free slot.
  assign occupancy = {1'b0, count_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue     = (state_q == S_RUN) && (rem_q != '0) && (occupancy < 3'd2);

`ifdef IMG_STREAM_BOUND_CHECK_EN
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  logic [SUM_W-1:0] base_ext;
  logic [SUM_W-1:0] end_ext;

  assign base_ext  = SUM_W'(base_addr);
  assign end_ext   = base_ext + SUM_W'(length);
  assign range_bad = (base_ext >= SUM_W'(IMG_SIZE)) || (end_ext > SUM_W'(IMG_SIZE));
  assign addr_inc  = addr_q + 1'b1;
`else
  assign range_bad = 1'b0;
  assign addr_inc  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (length == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_inc;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
        end else if (rem_q == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finish as soon as the final pixel is being accepted this cycle.
        if (!rd_pend_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      rd_pend_q <= issue;
      rd_last_q <= issue && (rem_q == LEN_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Each FIFO slot carries the pixel plus a tag marking the final pixel of the run.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_W-1:0] data_q;
      logic              last_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          last_q <= 1'b0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          data_q <= mem_rd;
          last_q <= rd_last_q;
        end
      end
    end
  endgenerate

  assign head_data = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;
  assign head_last = rd_ptr_q ? g_entry[1].last_q : g_entry[0].last_q;

  assign mem_a     = addr_q;
  assign mem_re    = issue;
  assign mem_we    = 1'b0;
  assign mem_wd    = '0;
  assign pix_valid = (count_q != 2'd0);
  assign pix_data  = head_data;
  assign pix_last  = pix_valid && head_last;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_image_memory_streamer.sv
// Testbench for image_memory_streamer: a queue-based model of each run (expected
// addresses and pixels) checked every cycle, plus literal pins on latency and wrap.
module tb_image_memory_streamer;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int IMG    = 160000;
  localparam int LEN_W  = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic              pix_last;
  logic              busy;
  logic              done;
  logic              err;

  image_memory_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_SIZE(IMG), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .mem_a(mem_a), .mem_re(mem_re), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [7:0] mem [IMG];
  always @(posedge clk) if (mem_re && (int'(mem_a) < IMG)) mem_rd <= mem[mem_a];

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_dat_q[$];
  bit         exp_last_q[$];
  int         exp_addr_q[$];
  int issued = 0, accepted = 0;
  int done_due = -1, err_from = -1, done_cyc = -1;
  bit chk_en = 1'b0;
  int ready_mode = 0, pat_idx = 0;

  int re_cyc_q[$], re_addr_q[$], acc_cyc_q[$], acc_dat_q[$];
  bit acc_last_q[$];

  function automatic void check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endfunction

  // Consumer readiness: always ready, the 1,0,0,1 pattern, or random.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: begin
        pix_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end
      default: pix_ready = ($urandom % 3) != 0;
    endcase
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_re) begin
        issued++;
        re_cyc_q.push_back(cycle);
        re_addr_q.push_back(int'(mem_a));
        check("mem_re_expected", longint'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("mem_a", mem_a, exp_addr_q.pop_front());
      end
      if (pix_valid) begin
        check("pix_valid_expected", longint'(exp_dat_q.size() > 0), 1);
        if (exp_dat_q.size() > 0) begin
          check("pix_data", pix_data, exp_dat_q[0]);
          check("pix_last", pix_last, exp_last_q[0]);
          if (pix_ready) begin
            accepted++;
            acc_cyc_q.push_back(cycle);
            acc_dat_q.push_back(int'(pix_data));
            acc_last_q.push_back(pix_last);
            if (exp_last_q[0]) done_due = cycle + 1;
            void'(exp_dat_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
      end
      check("outstanding_le_2", longint'((issued - accepted) <= 2), 1);
      check("done", done, longint'(cycle == done_due));
      if (done) begin
        done_cyc = cycle;
        check("busy_at_done", busy, 0);
      end
      check("err", err, longint'((err_from >= 0) && (cycle >= err_from)));
      check("mem_we_wd", {mem_we, mem_wd}, 0);
    end
  end

  function automatic void clear_logs();
    re_cyc_q.delete(); re_addr_q.delete();
    acc_cyc_q.delete(); acc_dat_q.delete(); acc_last_q.delete();
    done_cyc = -1;
  endfunction

  task automatic do_start(input int b, input int l, output int sc);
    bit bad;
    @(posedge clk);
    #2;
    start = 1'b1;
    base_addr = ADDR_W'(b);
    length = LEN_W'(l);
    sc = cycle;
`ifdef IMG_STREAM_BOUND_CHECK_EN
    bad = (b >= IMG) || (b + l > IMG);
`else
    bad = 1'b0;
`endif
    if (bad) begin
      if (err_from < 0) err_from = sc + 1;
      done_due = sc + 1;
    end else if (l == 0) begin
      done_due = sc + 1;
    end else begin
      for (int i = 0; i < l; i++) begin
        int a;
        a = (b + i) % IMG;
        exp_addr_q.push_back(a);
        exp_dat_q.push_back(mem[a]);
        exp_last_q.push_back(i == l - 1);
      end
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    length = LEN_W'($urandom);
    if (!bad && l > 0) check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    #1;
    check({"done_seen_", tag}, seen, 1);
    check({"pixels_left_", tag}, exp_dat_q.size(), 0);
    check({"reads_left_", tag}, exp_addr_q.size(), 0);
  endtask

  initial begin
    int sc;
    int wrap_exp[4] = '{159998, 159999, 0, 1};
    for (int i = 0; i < IMG; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);

    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs",
          {mem_re, mem_a, pix_valid, pix_data, pix_last, busy, done, err, mem_we, mem_wd}, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic run with literal latency expectations.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    clear_logs();
    do_start(0, 4, sc);
    wait_done("basic");
    check("basic_re_count", re_cyc_q.size(), 4);
    if (re_cyc_q.size() > 0) check("basic_first_re_cycle", re_cyc_q[0] - sc, 1);
    check("basic_accept_count", acc_cyc_q.size(), 4);
    for (int i = 0; i < acc_cyc_q.size() && i < 4; i++) begin
      check("basic_pix_cycle", acc_cyc_q[i] - sc, 3 + i);
      check("basic_pix_data", acc_dat_q[i], i + 1);
      check("basic_pix_last", acc_last_q[i], longint'(i == 3));
    end
    check("basic_done_cycle", done_cyc - sc, 7);
    $display("run basic base=0 length=4 pixels=%0d", acc_cyc_q.size());

    // Backpressure with an ignored start pulsed mid-run.
    ready_mode = 1;
    pat_idx = 0;
    clear_logs();
    do_start(40000, 8, sc);
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_ignored_start", busy, 1);
    start = 1'b1;
    base_addr = ADDR_W'(7);
    length = LEN_W'(3);
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("backpressure");
    check("bp_re_count", re_cyc_q.size(), 8);
    check("bp_accept_count", acc_cyc_q.size(), 8);
    $display("run backpressure base=40000 length=8 pixels=%0d", acc_cyc_q.size());

    // Zero length: done next cycle, no reads.
    ready_mode = 0;
    clear_logs();
    do_start(123, 0, sc);
    wait_done("zero");
    check("zero_re_count", re_cyc_q.size(), 0);
    check("zero_done_cycle", done_cyc - sc, 1);
    $display("run zero-length base=123 length=0 reads=%0d", re_cyc_q.size());

`ifdef IMG_STREAM_BOUND_CHECK_EN
    clear_logs();
    do_start(159998, 4, sc);
    wait_done("bound");
    check("bound_re_count", re_cyc_q.size(), 0);
    check("bound_err", err, 1);
    check("bound_done_cycle", done_cyc - sc, 1);
    clear_logs();
    do_start(100, 5, sc);
    wait_done("after_bound");
    check("after_bound_pixels", acc_cyc_q.size(), 5);
    check("err_sticky", err, 1);
    $display("run bound-check base=159998 length=4 err=%0d", err);
`else
    clear_logs();
    do_start(159998, 4, sc);
    wait_done("wrap");
    check("wrap_re_count", re_addr_q.size(), 4);
    for (int i = 0; i < re_addr_q.size() && i < 4; i++) check("wrap_mem_a", re_addr_q[i], wrap_exp[i]);
    $display("run wrap base=159998 length=4 pixels=%0d", acc_cyc_q.size());
`endif

    // Reset mid-run at address 500.
    ready_mode = 2;
    clear_logs();
    do_start(500, 50, sc);
    check("reset_precond_mem_a", mem_a, 500);
    check("reset_precond_mem_re", mem_re, 1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_midrun_outputs",
          {mem_re, mem_a, pix_valid, pix_data, pix_last, busy, done, err, mem_we, mem_wd}, 0);
    exp_dat_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
    issued = 0; accepted = 0; done_due = -1; err_from = -1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_pix_valid", pix_valid, 0);
    check("post_reset_busy", busy, 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle_no_re", mem_re, 0);
    $display("run reset-midrun base=500 length=50 aborted");

    // Randomised runs, some near the wrap point.
    for (int k = 0; k < 12; k++) begin
      int b, l;
      ready_mode = (k % 2 == 1) ? 2 : 0;
      b = (k % 3 == 0) ? (IMG - 1 - int'($urandom_range(0, 20))) : int'($urandom_range(0, IMG - 1));
      l = (k == 5) ? 1 : int'($urandom_range(1, 40));
      clear_logs();
      do_start(b, l, sc);
      wait_done("random");
      $display("run random %0d base=%0d length=%0d pixels=%0d", k, b, l, acc_cyc_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
